mul_div_unit: RTL

- Parametrised iterative multiply/divide unit for the EX stage.
- Successor to the fixed 16-step multiplier that runs on its own clock with a sync pulse.
- Runs on the system clock with an explicit start/busy/done handshake and a cancel (flush) input.
- Adds signed/unsigned modes and division; results go to HI/LO-style outputs for write-back.

---
 rtl/mdu_pkg.sv | 13 +
 rtl/mdu_negate.sv | 12 +
 rtl/mul_div_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: y = neg ? -x : x.
module mdu_negate #(
    parameter int N = 32
) (
    input  logic         neg,
    input  logic [N-1:0] x,
    output logic [N-1:0] y
);

    assign y = neg ? (~x + N'(1)) : x;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit with start/busy/done handshake and cancel.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    logic [1:0]         state;
    logic [CW-1:0]      count;
    logic [1:0]         op_reg;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   opb_reg;
    logic [WIDTH-1:0]   a_raw;
    logic               res_neg;
    logic               rem_neg;

    logic               signed_in;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;

    assign signed_in = (op == OP_MUL) || (op == OP_DIV);
    assign busy      = (state != S_IDLE);

    mdu_negate #(.N(WIDTH)) u_neg_a (
        .neg (signed_in & a[WIDTH-1]),
        .x   (a),
        .y   (a_abs)
    );

    mdu_negate #(.N(WIDTH)) u_neg_b (
        .neg (signed_in & b[WIDTH-1]),
        .x   (b),
        .y   (b_abs)
    );

    mdu_negate #(.N(2*WIDTH)) u_neg_prod (
        .neg (res_neg),
        .x   (acc),
        .y   (prod_fix)
    );

    mdu_negate #(.N(WIDTH)) u_neg_quot (
        .neg (res_neg),
        .x   (acc[WIDTH-1:0]),
        .y   (quot_fix)
    );

    mdu_negate #(.N(WIDTH)) u_neg_rem (
        .neg (rem_neg),
        .x   (rem[WIDTH-1:0]),
        .y   (rem_fix)
    );

    // Multiply adds the multiplicand into the upper half; divide trial-subtracts with one guard bit.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb_reg} : '0);
    assign div_diff = {rem, acc[WIDTH-1]} - {2'b00, opb_reg};
    assign div_ok   = ~div_diff[WIDTH+1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            count       <= '0;
            op_reg      <= OP_MULU;
            acc         <= '0;
            rem         <= '0;
            opb_reg     <= '0;
            a_raw       <= '0;
            res_neg     <= 1'b0;
            rem_neg     <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        state   <= S_CALC;
                        count   <= CW'(WIDTH);
                        op_reg  <= op;
                        a_raw   <= a;
                        opb_reg <= b_abs;
                        acc     <= {{WIDTH{1'b0}}, a_abs};
                        rem     <= '0;
                        res_neg <= signed_in & (a[WIDTH-1] ^ b[WIDTH-1]) & (b != '0);
                        rem_neg <= signed_in & a[WIDTH-1];
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        state <= S_IDLE;
                        count <= '0;
                    end else begin
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state <= S_FIX;
                        end
                        if (op_reg[1]) begin
                            rem <= div_ok ? div_diff[WIDTH:0] : {rem[WIDTH-1:0], acc[WIDTH-1]};
                            acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ok};
                        end else begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    count <= '0;
                    // A flush arriving in the final cycle suppresses both done and the write-back.
                    if (!cancel) begin
                        done <= 1'b1;
                        case (op_reg)
                            OP_MULU, OP_MUL: begin
                                hi          <= prod_fix[2*WIDTH-1:WIDTH];
                                lo          <= prod_fix[WIDTH-1:0];
                                div_by_zero <= 1'b0;
                            end
                            default: begin
                                if (opb_reg == '0) begin
                                    hi          <= a_raw;
                                    lo          <= '1;
                                    div_by_zero <= 1'b1;
                                end else begin
                                    hi          <= rem_fix;
                                    lo          <= quot_fix;
                                    div_by_zero <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state <= S_IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
